// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Command-side master for the 8-bit accumulator ALU. It takes one command per
// cmd_valid/cmd_ready handshake and expands it into the ALU opcode/data_in
// cycle sequence, including the register-A load. It then samples the ALU
// data_out and flags and returns them on a rsp_valid/rsp_ready handshake.
//
// Parameters
//   DATA_WIDTH        operand / ALU data / response data width (default 8)
//
// Ports
//   clk               system clock, all state on the rising edge
//   a_reset           asynchronous, active-high reset
//   cmd_valid/ready   command handshake (ready only in IDLE)
//   cmd_op[3:0]       0=RESET 1=ADD 2=SUB 3=AND 4=OR 5=XOR 6=LSHIFT 7=RSHIFT
//                     8=LOADA 9=READ, A-F illegal
//   cmd_operand       register-A value, sampled at acceptance only
//   rsp_valid/ready   response handshake
//   rsp_data          ALU data_out captured in SETTLE
//   rsp_zero/rsp_ovf  ALU flags captured in SETTLE
//   rsp_err           command was illegal, no ALU opcode issued
//   alu_opcode        registered opcode to the ALU (4'hF = NOOP when idle)
//   alu_data_in       registered data to the ALU
//   alu_data_out      ALU output register
//   alu_acc_zero      ALU zero flag
//   alu_acc_overflow  ALU overflow flag
//
// Build option
//   ALU_SEQ_AUTO_OUT_EN  when defined, ops 0-7 get one extra cycle that
//                        issues ALU OUT (9) after EXEC, so rsp_data carries
//                        the fresh accumulator low byte.
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  a_reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_operand,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_zero,
    output logic                  rsp_ovf,
    output logic                  rsp_err,

    output logic [3:0]            alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_data_in,
    input  logic [DATA_WIDTH-1:0] alu_data_out,
    input  logic                  alu_acc_zero,
    input  logic                  alu_acc_overflow
);

    localparam logic [3:0] OP_RESET = 4'h0;
    localparam logic [3:0] OP_LOADA = 4'h8;
    localparam logic [3:0] OP_OUT   = 4'h9;
    localparam logic [3:0] OP_NOOP  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADA,
        S_EXEC,
        S_SETTLE,
        S_RESP
`ifdef ALU_SEQ_AUTO_OUT_EN
        ,
        S_OUT
`endif
    } state_t;

    state_t                  r_state;
    state_t                  w_nxt_state;

    logic [3:0]              r_op;
    logic [3:0]              r_alu_opcode;
    logic [DATA_WIDTH-1:0]   r_alu_data_in;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic                    r_rsp_zero;
    logic                    r_rsp_ovf;
    logic                    r_rsp_err;

    logic                    w_accept;
    logic                    w_illegal;
    logic [3:0]              w_op;
    logic [3:0]              w_nxt_opcode;
    logic [DATA_WIDTH-1:0]   w_nxt_data_in;

    assign w_illegal = (cmd_op > OP_OUT);

    // In IDLE the command has not been latched yet, so the opcode for the
    // first issued cycle must come straight from the command port.
    assign w_op = (r_state == S_IDLE) ? cmd_op : r_op;

    // ---------------------------------------------------------------------
    // Next-state and next-ALU-output logic. The ALU outputs are registered
    // from the next state, so the opcode is on the wire during the cycle
    // the FSM spends in the matching state.
    // ---------------------------------------------------------------------
    always_comb begin
        w_nxt_state   = r_state;
        w_accept      = 1'b0;
        w_nxt_opcode  = OP_NOOP;
        w_nxt_data_in = r_alu_data_in;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    case (cmd_op)
                        4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                        OP_LOADA:                     w_nxt_state = S_LOADA;
                        OP_RESET, 4'h6, 4'h7, OP_OUT: w_nxt_state = S_EXEC;
                        default:                      w_nxt_state = S_RESP;
                    endcase
                end
            end
            S_LOADA: begin
                w_nxt_state = (r_op == OP_LOADA) ? S_SETTLE : S_EXEC;
            end
            S_EXEC: begin
`ifdef ALU_SEQ_AUTO_OUT_EN
                w_nxt_state = (r_op <= 4'h7) ? S_OUT : S_SETTLE;
`else
                w_nxt_state = S_SETTLE;
`endif
            end
`ifdef ALU_SEQ_AUTO_OUT_EN
            S_OUT: begin
                w_nxt_state = S_SETTLE;
            end
`endif
            S_SETTLE: begin
                w_nxt_state = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_nxt_state = S_IDLE;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        case (w_nxt_state)
            S_LOADA: begin
                w_nxt_opcode  = OP_LOADA;
                w_nxt_data_in = cmd_operand;
            end
            S_EXEC: begin
                w_nxt_opcode = w_op;
            end
`ifdef ALU_SEQ_AUTO_OUT_EN
            S_OUT: begin
                w_nxt_opcode = OP_OUT;
            end
`endif
            default: begin
                w_nxt_opcode = OP_NOOP;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            r_state       <= S_IDLE;
            r_op          <= '0;
            r_alu_opcode  <= OP_NOOP;
            r_alu_data_in <= '0;
            r_rsp_data    <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_ovf     <= 1'b0;
            r_rsp_err     <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_alu_opcode  <= w_nxt_opcode;
            r_alu_data_in <= w_nxt_data_in;

            if (w_accept) begin
                r_op <= cmd_op;
                // Illegal commands skip the ALU entirely; data/flags keep
                // the previous response values.
                if (w_illegal) begin
                    r_rsp_err <= 1'b1;
                end
            end

            if (r_state == S_SETTLE) begin
                r_rsp_data <= alu_data_out;
                r_rsp_zero <= alu_acc_zero;
                r_rsp_ovf  <= alu_acc_overflow;
                r_rsp_err  <= 1'b0;
            end
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_data    = r_rsp_data;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_ovf     = r_rsp_ovf;
    assign rsp_err     = r_rsp_err;
    assign alu_opcode  = r_alu_opcode;
    assign alu_data_in = r_alu_data_in;

endmodule
